// File: rtl/lifo.sv
// lifo: DTI valid/ready stack buffer; newest word on dout, push-over-pop replaces the top.
// Define LIFO_STATUS_EN to add the full/empty/level status outputs.
module lifo #(
  parameter int DEPTH = 64,
  parameter int DIN   = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DIN-1:0] i_din_data,
  input  logic           i_din_valid,
  output logic           o_din_ready,
  output logic [DIN-1:0] o_dout_data,
  output logic           o_dout_valid,
  input  logic           i_dout_ready
`ifdef LIFO_STATUS_EN
  ,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_level
`endif
);
  localparam int AW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);
  logic [DIN-1:0] r_ram [DEPTH];
  logic [AW-1:0]  r_sp;
  logic           w_empty, w_full, w_push, w_pop;
  logic [IW-1:0]  w_top, w_widx;
  always_comb begin
    w_empty      = r_sp == '0;
    w_full       = r_sp == AW'(DEPTH);
    o_dout_valid = ~w_empty;
    o_din_ready  = ~w_full | i_dout_ready;
    w_push       = i_din_valid & o_din_ready;
    w_pop        = o_dout_valid & i_dout_ready;
    w_top        = IW'(r_sp - AW'(1));
    // a simultaneous pop frees the top slot, so the new word lands there
    w_widx       = w_pop ? w_top : IW'(r_sp);
    o_dout_data  = r_ram[w_top];
  end
  always_ff @(posedge clk)
    if (rst && w_push) r_ram[w_widx] <= i_din_data;
  always_ff @(posedge clk)
    if (!rst) r_sp <= '0;
    else if (w_push && !w_pop) r_sp <= r_sp + AW'(1);
    else if (w_pop && !w_push) r_sp <= r_sp - AW'(1);
`ifdef LIFO_STATUS_EN
  always_comb begin
    o_full  = w_full;
    o_empty = w_empty;
    o_level = r_sp;
  end
`endif
endmodule

// File: tb/tb_lifo.sv
// tb_lifo: directed test-plan steps then random traffic, checked against a queue model of the stack.
module tb_lifo;
  localparam int DEPTH = 4;
  localparam int DIN   = 16;
  localparam int AW    = $clog2(DEPTH+1);
  logic           clk = 0, rst = 0;
  logic [DIN-1:0] din_data = '0, dout_data;
  logic           din_valid = 0, din_ready, dout_valid, dout_ready = 0;
`ifdef LIFO_STATUS_EN
  logic           full, empty;
  logic [AW-1:0]  level;
`endif
  int errors = 0, checks = 0;
  logic [DIN-1:0] q[$];
  lifo #(.DEPTH(DEPTH), .DIN(DIN)) dut (
    .clk(clk), .rst(rst),
    .i_din_data(din_data), .i_din_valid(din_valid), .o_din_ready(din_ready),
    .o_dout_data(dout_data), .o_dout_valid(dout_valid), .i_dout_ready(dout_ready)
`ifdef LIFO_STATUS_EN
    , .o_full(full), .o_empty(empty), .o_level(level)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic v, input logic [DIN-1:0] d, input logic r, input logic rs = 1'b1);
    logic exp_rdy, push, pop;
    @(negedge clk);
    din_valid = v; din_data = d; dout_ready = r; rst = rs;
    #1;
    if (!rs) q.delete();
    else begin
      exp_rdy = (q.size() < DEPTH) || r;
      push    = v && exp_rdy;
      pop     = (q.size() != 0) && r;
      chk("dout_valid", dout_valid, q.size() != 0);
      chk("din_ready", din_ready, exp_rdy);
      if (q.size() != 0) chk("dout_data", dout_data, q[$]);
`ifdef LIFO_STATUS_EN
      chk("full", full, q.size() == DEPTH);
      chk("empty", empty, q.size() == 0);
      chk("level", level, q.size());
`endif
      if (pop) void'(q.pop_back());
      if (push) q.push_back(d);
    end
  endtask
  initial begin
    step(0, 0, 0, 0);
    step(0, 0, 0);
    chk("reset_valid", dout_valid, 0);
    chk("reset_ready", din_ready, 1);
    step(1, 'h11, 0); step(1, 'h22, 0); step(1, 'h33, 0);
    step(0, 0, 1); chk("order_33", dout_data, 'h33);
    step(0, 0, 1); chk("order_22", dout_data, 'h22);
    step(0, 0, 1); chk("order_11", dout_data, 'h11);
    step(0, 0, 0); chk("order_drained", dout_valid, 0);
    step(1, 'h01, 0); step(1, 'h02, 0); step(1, 'h03, 0); step(1, 'h44, 0);
    step(1, 'h55, 0); chk("full_ready", din_ready, 0);
    step(0, 0, 0); chk("full_top_kept", dout_data, 'h44);
    step(1, 'hAA, 1); chk("fullpop_old", dout_data, 'h44);
    chk("fullpop_ready", din_ready, 1);
    step(0, 0, 0); chk("fullpop_new", dout_data, 'hAA);
    chk("fullpop_still_full", din_ready, 0);
    step(0, 0, 0, 0);
    step(1, 'h01, 0); step(1, 'hBB, 0);
    step(1, 'hCC, 1); chk("mid_old", dout_data, 'hBB);
    step(0, 0, 0); chk("mid_new", dout_data, 'hCC);
    step(0, 0, 1);
    step(0, 0, 0); chk("mid_below", dout_data, 'h01);
    step(0, 0, 0, 0);
    step(1, 'h5A, 0); chk("empty_push_nofall", dout_valid, 0);
    step(0, 0, 0); chk("empty_push_valid", dout_valid, 1);
    chk("empty_push_data", dout_data, 'h5A);
    step(0, 0, 0, 0);
    step(1, 'h61, 0); step(1, 'h62, 0); step(1, 'h63, 0);
    step(1, 'h77, 0, 0);
    step(0, 0, 0); chk("rst_valid", dout_valid, 0);
    chk("rst_ready", din_ready, 1);
    step(1, 'h09, 0);
    step(0, 0, 1); chk("rst_one_word", dout_data, 'h09);
    step(0, 0, 0); chk("rst_nothing_left", dout_valid, 0);
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 2) != 0), DIN'($urandom), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 199) != 0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lifo.md
# lifo

Last-in-first-out buffer on the DTI valid/ready/data protocol. It is the reverse-order counterpart of the existing FIFO and shares the same port shape, so the two are interchangeable in a pipeline. It accepts words on a DTI consumer port, stores them in an inferred RAM stack and presents the most recently accepted word on a DTI producer port. It is used wherever a gear must emit a collected sequence in reverse order, for example reversal stages and depth-first traversal buffers.

## Interface
- DEPTH, 64: stack capacity in words; must be 2 or more.
- DIN, 16: data width in bits.
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-low reset. Asserted when 0 and sampled on the rising edge of clk.
- din  dti.consumer  DIN  write side, carrying data, valid and ready.
- dout  dti.producer  DIN  read side, carrying data, valid and ready.
- full, empty, level  output  1, 1, $clog2(DEPTH+1)  status outputs; present only with LIFO_STATUS_EN.

## Operation
- State is a stack pointer `sp`, $clog2(DEPTH+1) bits wide, ranging 0..DEPTH. It holds the number of stored words.
- `empty` = (sp == 0). `full` = (sp == DEPTH).
- Output side:
  - dout.valid = ~empty.
  - dout.data = ram[sp-1], read combinationally.
  - dout.data is don't-care while empty.
- Input side: din.ready = ~full | dout.ready. A push is therefore accepted when full if a pop happens in the same cycle.
- Handshake terms: push = din.valid & din.ready; pop = dout.valid & dout.ready.
- Per-cycle update:
  - push only: ram[sp] <= din.data, sp <= sp+1.
  - pop only: sp <= sp-1.
  - push and pop together: ram[sp-1] <= din.data and sp is unchanged. The new word replaces the popped top.
  - neither: no change.
- No fall-through. A word pushed into an empty stack is visible on dout the next cycle.
- RAM contents are not reset. Only sp is reset.

## Timing
- Reset (rst = 0 at a clk edge) sets sp <= 0. After reset:
  - dout.valid = 0.
  - din.ready = 1.
  - full = 0, empty = 1, level = 0.
- Reset asserted mid-operation discards all stored words in one cycle. Any handshake in that cycle is ignored.
- Push-to-pop latency is 1 cycle.
- Throughput is 1 push and 1 pop per cycle.
- Combinational paths:
  - dout.ready -> din.ready exists.
  - din.valid -> dout.valid does not exist.
  - din.data -> dout.data does not exist.
- Producer rule: dout.valid and dout.data stay stable until dout.ready, unless a push in the same cycle changes the top. That is legal because the top is consumed in that same cycle.
- Consumer rule: din.valid and din.data are held by the upstream until din.ready.
- Boundaries:
  - sp never wraps.
  - A pop at sp = 0 is impossible because dout.valid = 0.
  - A push-only at sp = DEPTH is impossible because din.ready = 0 when dout.ready = 0.

## Configuration
- LIFO_STATUS_EN: when defined, adds the outputs full, empty and level (level = sp). All three are registered-state derived and glitch-free.
- When undefined, those ports and their logic are absent. Core behaviour is identical either way.

## Test plan
- LIFO order: DEPTH = 4. Push 0x11, 0x22, 0x33 with dout.ready = 0, then set dout.ready = 1. Required: dout gives 0x33, 0x22, 0x11 on consecutive cycles, then dout.valid = 0.
- Full backpressure: push 4 words with dout.ready = 0. Required: din.ready = 0 and full = 1 after the 4th push; a 5th din.valid is not accepted and sp stays 4.
- Push while full with pop: stack full with top 0x44. Drive din.valid with 0xAA and dout.ready = 1. Required: 0x44 is popped, 0xAA becomes the new top next cycle, sp stays 4.
- Simultaneous push/pop mid-stack: sp = 2 with top 0xBB. Push 0xCC and pop in the same cycle. Required: dout shows 0xBB that cycle, 0xCC the next cycle, level stays 2.
- Empty push: push 0x5A into an empty stack. Required: dout.valid = 0 that cycle and 1 with data 0x5A the next cycle.
- Reset mid-operation: sp = 3, then drive rst = 0 for one edge while din.valid = 1. Required: the next cycle has dout.valid = 0, empty = 1, level = 0, and no word is stored.
